// File: rtl/bus_pkg.sv
// Shared bus definitions: field widths, CRC polynomial, broadcast address and
// receiver FSM states, common to the transmitter, arbiter and receiver.
package bus_pkg;

  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned CRC_W      = 4;
  localparam int unsigned FRAME_BITS = 78;
  localparam int unsigned CNT_W      = 7;

  localparam logic [CRC_W-1:0]  CRC_POLY       = 4'b0011;
  localparam logic [ADDR_W-1:0] DEF_BCAST_ADDR = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRC,
    ST_DST,
    ST_DATA,
    ST_CRC,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/crc4_serial.sv
// Bit-serial CRC-4 (x^4+x+1), MSB-first, zero initial value, no final XOR.
module crc4_serial
  import bus_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_W-1] ^ bit_in;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/bus_frame_receiver.sv
// Serial frame receiver: deframes start/src/dst/data/crc/stop, filters on
// destination address and CRC-4, and holds accepted payloads for a valid/ready consumer.
module bus_frame_receiver
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] NODE_ADDR  = 4'h1,
  parameter logic [ADDR_W-1:0] BCAST_ADDR = DEF_BCAST_ADDR
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bus_in,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [ADDR_W-1:0] rx_src,
  output logic [DATA_W-1:0] rx_data,
  output logic              crc_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  rx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] src_sr, dst_sr;
  logic [DATA_W-1:0] data_sr;
  logic [CRC_W-1:0]  crc_sr, crc_calc;
  logic              crc_clear, crc_en;

  logic stop_edge, addr_ok, crc_ok;
  logic frame_bad, crc_bad, frame_good, frame_drop, frame_load;

  crc4_serial u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (crc_clear),
    .enable  (crc_en),
    .bit_in  (bus_in),
    .crc     (crc_calc)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Each field state counts down from (width-1); the counter is reloaded on entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? '0 : cnt - 1'b1;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        crc_clear = 1'b1;
        cnt_nxt   = '0;
        if (!bus_in) begin
          state_nxt = ST_SRC;
          cnt_nxt   = CNT_W'(ADDR_W - 1);
        end
      end
      ST_SRC: begin
        if (cnt == '0) begin
          state_nxt = ST_DST;
          cnt_nxt   = CNT_W'(ADDR_W - 1);
        end
      end
      ST_DST: begin
        crc_en = 1'b1;
        if (cnt == '0) begin
          state_nxt = ST_DATA;
          cnt_nxt   = CNT_W'(DATA_W - 1);
        end
      end
      ST_DATA: begin
        crc_en = 1'b1;
        if (cnt == '0) begin
          state_nxt = ST_CRC;
          cnt_nxt   = CNT_W'(CRC_W - 1);
        end
      end
      ST_CRC: begin
        if (cnt == '0) begin
          state_nxt = ST_STOP;
          cnt_nxt   = '0;
        end
      end
      ST_STOP: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign stop_edge  = (state == ST_STOP);
  assign addr_ok    = (dst_sr == NODE_ADDR) || (dst_sr == BCAST_ADDR);
  assign crc_ok     = (crc_sr == crc_calc);
  assign frame_bad  = stop_edge && !bus_in;
  assign crc_bad    = stop_edge && bus_in && addr_ok && !crc_ok;
  assign frame_good = stop_edge && bus_in && addr_ok && crc_ok;
  // A handshake on the stop edge frees the holding register, so no overrun then.
  assign frame_drop = frame_good && rx_valid && !rx_ready;
  assign frame_load = frame_good && !frame_drop;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      src_sr    <= '0;
      dst_sr    <= '0;
      data_sr   <= '0;
      crc_sr    <= '0;
      rx_valid  <= 1'b0;
      rx_src    <= '0;
      rx_data   <= '0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      crc_err   <= crc_bad;
      frame_err <= frame_bad;
      overrun   <= frame_drop;
      busy      <= (state_nxt != ST_IDLE);
      case (state)
        ST_SRC:  src_sr  <= {src_sr[ADDR_W-2:0], bus_in};
        ST_DST:  dst_sr  <= {dst_sr[ADDR_W-2:0], bus_in};
        ST_DATA: data_sr <= {data_sr[DATA_W-2:0], bus_in};
        ST_CRC:  crc_sr  <= {crc_sr[CRC_W-2:0], bus_in};
        default: ;
      endcase
      if (frame_load) begin
        rx_valid <= 1'b1;
        rx_src   <= src_sr;
        rx_data  <= data_sr;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
